brick_field: RTL



---
 rtl/brick_field.sv | 131 +++++++++++++
 1 files changed

// File: rtl/brick_field.sv
// Playfield occupancy map for the brick game: brick clearing, paddle row, score and lives.
// Optional brick reload after the last brick falls is enabled with `define BRICK_RESPAWN_EN.
module brick_field #(
    parameter int BRICK_ROWS   = 4,
    parameter int PADDLE_W     = 4,
    parameter int PADDLE_START = 6,
    parameter int LIVES        = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [3:0]   Ball_rowIndex,
    input  logic [3:0]   Ball_colIndex,
    input  logic [1:0]   Ball_direction,
    output logic [191:0] data,
    output logic         IsGameOver,
    output logic [3:0]   Paddle_colIndex,
    output logic [7:0]   score,
    output logic [3:0]   lives
);

    localparam logic [175:0] BRICK_INIT  = (176'(1) << (BRICK_ROWS * 16)) - 176'(1);
    localparam logic [15:0]  PADDLE_BITS = 16'((32'(1) << PADDLE_W) - 32'(1));
    localparam logic [15:0]  PADDLE_INIT = 16'(PADDLE_BITS << PADDLE_START);
    localparam logic [4:0]   PADDLE_MAX  = 5'(16 - PADDLE_W);

    typedef enum logic [1:0] {PLAY, MISS, DONE} state_t;
    state_t state;

    logic         going_up;
    logic         going_right;
    logic         ball_in_field;
    logic [4:0]   v_row;
    logic [4:0]   h_col;
    logic         v_ok;
    logic         h_ok;
    logic [7:0]   v_idx;
    logic [7:0]   h_idx;
    logic [7:0]   d_idx;
    logic         hit_v;
    logic         hit_h;
    logic         hit_d;
    logic [175:0] clear_mask;
    logic [1:0]   clear_count;
    logic [8:0]   score_sum;
    logic         all_clear;
    logic         miss;
    logic [3:0]   paddle_next;
    logic [15:0]  paddle_row;

    // Neighbour cells are only considered inside the clearable rows 0..10.
    always_comb begin
        going_up      = ~Ball_direction[1];
        going_right   = ~Ball_direction[0];
        ball_in_field = Ball_rowIndex <= 4'd10;
        v_row = going_up ? ({1'b0, Ball_rowIndex} - 5'd1) : ({1'b0, Ball_rowIndex} + 5'd1);
        h_col = going_right ? ({1'b0, Ball_colIndex} - 5'd1) : ({1'b0, Ball_colIndex} + 5'd1);
        v_ok  = ball_in_field && (v_row <= 5'd10);
        h_ok  = ball_in_field && (h_col <= 5'd15);
        v_idx = {v_row[3:0], Ball_colIndex};
        h_idx = {Ball_rowIndex, h_col[3:0]};
        d_idx = {v_row[3:0], h_col[3:0]};
        hit_v = v_ok && data[v_idx];
        hit_h = h_ok && data[h_idx];
        hit_d = v_ok && h_ok && data[d_idx] && !hit_v && !hit_h;

        clear_mask = '0;
        if (hit_v) clear_mask[v_idx] = 1'b1;
        if (hit_h) clear_mask[h_idx] = 1'b1;
        if (hit_d) clear_mask[d_idx] = 1'b1;
        clear_count = {1'b0, hit_v} + {1'b0, hit_h} + {1'b0, hit_d};
        score_sum   = {1'b0, score} + {7'd0, clear_count};

        all_clear = (data[175:0] == '0);
        miss      = (Ball_rowIndex == 4'd11);

        paddle_next = Paddle_colIndex;
        if (btn_left && !btn_right && ({1'b0, Paddle_colIndex} < PADDLE_MAX))
            paddle_next = Paddle_colIndex + 4'd1;
        else if (btn_right && !btn_left && (Paddle_colIndex != 4'd0))
            paddle_next = Paddle_colIndex - 4'd1;
        paddle_row = PADDLE_BITS << paddle_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= PLAY;
            data            <= {PADDLE_INIT, BRICK_INIT};
            IsGameOver      <= 1'b0;
            Paddle_colIndex <= 4'(PADDLE_START);
            score           <= 8'd0;
            lives           <= 4'(LIVES);
        end else begin
            // The paddle keeps moving in every state, including after game end.
            Paddle_colIndex  <= paddle_next;
            data[191:176]    <= paddle_row;
            case (state)
                PLAY: begin
                    if (all_clear) begin
`ifdef BRICK_RESPAWN_EN
                        data[175:0] <= BRICK_INIT;
                        state       <= MISS;
`else
                        state       <= DONE;
`endif
                        IsGameOver <= 1'b1;
                    end else if (miss) begin
                        lives      <= lives - 4'd1;
                        IsGameOver <= 1'b1;
                        state      <= (lives == 4'd1) ? DONE : MISS;
                    end else begin
                        data[175:0] <= data[175:0] & ~clear_mask;
                        score       <= score_sum[8] ? 8'hFF : score_sum[7:0];
                    end
                end
                MISS: begin
                    state      <= PLAY;
                    IsGameOver <= 1'b0;
                end
                DONE: begin
                    IsGameOver <= 1'b1;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule
